// File: rtl/counter_down_mod.sv
// Programmable modulo down-counter (MAX..0, wrap to MAX) with clamped load and same-cycle borrow.
// Define COUNTER_DOWN_ONESHOT_EN to stop at 0 and raise a sticky one-shot done flag instead.
module counter_down_mod #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 5
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             iEn,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadVal,
    output logic [WIDTH-1:0] oCnt,
    output logic             oZero,
    output logic             oBorrow,
    output logic             oDone
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] load_clamped;
    logic             cnt_zero;
    logic             step;

    assign load_clamped = (iLoadVal > MaxVal) ? MaxVal : iLoadVal;
    assign cnt_zero     = (cnt_q == '0);
    // Enable only counts when no load is pending this cycle.
    assign step         = iEn & ~iLoad;

`ifdef COUNTER_DOWN_ONESHOT_EN
    logic done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (iLoad) begin
            cnt_d  = load_clamped;
            done_d = 1'b0;
        end else if (iEn) begin
            if (!cnt_zero) begin
                cnt_d = cnt_q - OneVal;
            end
            // Reaching 0 via a decrement, or stepping while already at 0 after a load of 0.
            if (cnt_q == OneVal || cnt_zero) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q  <= MaxVal;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign oDone   = done_q;
    assign oBorrow = step & cnt_zero & ~done_q;
`else
    always_comb begin
        cnt_d = cnt_q;
        if (iLoad) begin
            cnt_d = load_clamped;
        end else if (iEn) begin
            cnt_d = cnt_zero ? MaxVal : (cnt_q - OneVal);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= MaxVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oDone   = 1'b0;
    assign oBorrow = step & cnt_zero;
`endif

    assign oCnt  = cnt_q;
    assign oZero = cnt_zero;

endmodule

// File: tb/tb_counter_down_mod.sv
// Directed bench for counter_down_mod (WIDTH=3, MAX=5): single counter plus a chained pair.
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
`timescale 1ns/1ps
module tb_counter_down_mod;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       iEn = 1'b0;
    logic       iLoad = 1'b0;
    logic [2:0] iLoadVal = 3'd0;
    logic [2:0] oCnt;
    logic       oZero, oBorrow, oDone;

    logic       ch_en = 1'b0;
    logic [2:0] lo_cnt, hi_cnt;
    logic       lo_zero, lo_borrow, lo_done;
    logic       hi_zero, hi_borrow, hi_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    counter_down_mod #(.WIDTH(3), .MAX(5)) u_dut (
        .CLK(CLK), .RESETn(RESETn), .iEn(iEn), .iLoad(iLoad), .iLoadVal(iLoadVal),
        .oCnt(oCnt), .oZero(oZero), .oBorrow(oBorrow), .oDone(oDone)
    );

    counter_down_mod #(.WIDTH(3), .MAX(5)) u_lo (
        .CLK(CLK), .RESETn(RESETn), .iEn(ch_en), .iLoad(1'b0), .iLoadVal(3'd0),
        .oCnt(lo_cnt), .oZero(lo_zero), .oBorrow(lo_borrow), .oDone(lo_done)
    );

    counter_down_mod #(.WIDTH(3), .MAX(5)) u_hi (
        .CLK(CLK), .RESETn(RESETn), .iEn(lo_borrow), .iLoad(1'b0), .iLoadVal(3'd0),
        .oCnt(hi_cnt), .oZero(hi_zero), .oBorrow(hi_borrow), .oDone(hi_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [2:0] seq [14];
        seq = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
                3'd5, 3'd4};

        // Reset state
        #12;
        check("rst_cnt", 32'(oCnt), 32'd5);
        check("rst_zero", 32'(oZero), 32'd0);
        check("rst_borrow", 32'(oBorrow), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        tick();

`ifdef COUNTER_DOWN_ONESHOT_EN
        // One-shot: load 2 and count 6 cycles
        iLoad = 1'b1; iLoadVal = 3'd2;
        tick();
        iLoad = 1'b0; iEn = 1'b1;
        begin
            logic [2:0] os [6];
            logic       od [6];
            os = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
            od = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 6; i++) begin
                check($sformatf("os_cnt[%0d]", i), 32'(oCnt), 32'(os[i]));
                check($sformatf("os_done[%0d]", i), 32'(oDone), 32'(od[i]));
                check($sformatf("os_borrow[%0d]", i), 32'(oBorrow), 32'd0);
                tick();
            end
        end
        // Reload clears done; load of 0 borrows exactly once
        iEn = 1'b0; iLoad = 1'b1; iLoadVal = 3'd0;
        tick();
        iLoad = 1'b0;
        check("os_reload_done", 32'(oDone), 32'd0);
        iEn = 1'b1;
        #1;
        check("os_zero_load_borrow", 32'(oBorrow), 32'd1);
        tick();
        check("os_zero_load_done", 32'(oDone), 32'd1);
        check("os_zero_load_borrow2", 32'(oBorrow), 32'd0);
        check("os_zero_hold", 32'(oCnt), 32'd0);
        iEn = 1'b0;
`else
        // 1. Free-running wrap, 14 enabled cycles
        iEn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            check($sformatf("wrap_cnt[%0d]", i), 32'(oCnt), 32'(seq[i]));
            check($sformatf("wrap_borrow[%0d]", i), 32'(oBorrow), (i == 5 || i == 11) ? 32'd1 : 32'd0);
            tick();
        end
        check("wrap_end", 32'(oCnt), 32'd3);

        // 2. Load with clamp, then count down through wrap
        iEn = 1'b0; iLoad = 1'b1; iLoadVal = 3'd7;
        tick();
        check("clamp_7", 32'(oCnt), 32'd5);
        iLoadVal = 3'd2;
        tick();
        check("load_2", 32'(oCnt), 32'd2);
        iLoad = 1'b0; iEn = 1'b1;
        tick();
        check("after_load_1", 32'(oCnt), 32'd1);
        tick();
        check("after_load_0", 32'(oCnt), 32'd0);
        check("after_load_zero", 32'(oZero), 32'd1);
        check("after_load_borrow", 32'(oBorrow), 32'd1);
        tick();
        check("after_load_wrap", 32'(oCnt), 32'd5);
        check("done_tied", 32'(oDone), 32'd0);

        // 3. Load beats enable at 0; borrow suppressed
        iEn = 1'b0; iLoad = 1'b1; iLoadVal = 3'd0;
        tick();
        check("load_0", 32'(oCnt), 32'd0);
        check("idle_zero_borrow", 32'(oBorrow), 32'd0);
        iEn = 1'b1; iLoad = 1'b1; iLoadVal = 3'd3;
        #1;
        check("load_en_borrow", 32'(oBorrow), 32'd0);
        tick();
        check("load_en_cnt", 32'(oCnt), 32'd3);
        // Load of 0 then enable borrows
        iEn = 1'b0; iLoadVal = 3'd0;
        tick();
        iLoad = 1'b0; iEn = 1'b1;
        #1;
        check("zero_load_borrow", 32'(oBorrow), 32'd1);
        tick();
        check("zero_load_wrap", 32'(oCnt), 32'd5);

        // 5. Async reset mid-cycle at count 2
        tick(); tick(); tick();
        check("pre_rst_cnt", 32'(oCnt), 32'd2);
        #2;
        RESETn = 1'b0;
        #1;
        check("async_rst_cnt", 32'(oCnt), 32'd5);
        check("async_rst_borrow", 32'(oBorrow), 32'd0);
        #1;
        RESETn = 1'b1;
        tick();
        check("resume_cnt", 32'(oCnt), 32'd4);
        iEn = 1'b0;

        // 4. Chained pair: lower wraps every 6, upper steps on the same edge
        ch_en = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            if (i == 6) check("chain_lo_borrow6", 32'(lo_borrow), 32'd1);
            tick();
            if (i == 5) check("chain_hi5", 32'(hi_cnt), 32'd5);
            if (i == 6) begin
                check("chain_lo6", 32'(lo_cnt), 32'd5);
                check("chain_hi6", 32'(hi_cnt), 32'd4);
            end
            if (i == 12) check("chain_hi12", 32'(hi_cnt), 32'd3);
        end
        check("chain_lo36", 32'(lo_cnt), 32'd5);
        check("chain_hi36", 32'(hi_cnt), 32'd5);
        ch_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
